// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM encoding, grant side,
// default abort data and the round-robin grant helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DM_ACC = 2'd1,
    ST_IF_ACC = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // When both sides want the port, the side that did not win last time goes first.
  function automatic grant_t pick_grant(input logic dm_pend, input logic if_req,
                                        input grant_t last_grant);
    if (dm_pend && if_req) begin
      return (last_grant == GRANT_IF) ? GRANT_DM : GRANT_IF;
    end else if (dm_pend) begin
      return GRANT_DM;
    end
    return GRANT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External memory port bundle. The arbiter drives it through the master modport,
// the memory model answers through the slave modport.
// Handshake: mem_req is held with mem_addr/mem_we/mem_wdata stable until the
// memory returns mem_ack (sampled at posedge), which completes the access in that cycle.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter_access_watchdog.sv
// Per-access watchdog: counts cycles spent waiting for an ack and flags expiry
// on the last allowed cycle. Saturates instead of wrapping.
module access_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the EX/MEM data access,
// alternating on contention and stalling the pipeline until each access completes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            TIMEOUT_CYC = 16,
  parameter logic [DW-1:0] ERR_DATA    = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          exm_mem_read,
  input  logic          exm_mem_write,
  input  logic [AW-1:0] exm_addr,
  input  logic [DW-1:0] exm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          stall_fetch,
  output logic          stall_pipe,
  output logic          err_timeout,
  output arb_state_t    dbg_state,
  mem_port_arbiter_if.master mem
);

  arb_state_t    state_q, state_d;
  grant_t        last_grant_q, last_grant_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          err_timeout_q, err_timeout_d;

  logic          dm_pend, in_acc, ack_dm, ack_if, wd_expired, finish;
  logic [DW-1:0] ret_data;
  grant_t        grant;

  assign dm_pend  = exm_mem_read | exm_mem_write;
  assign in_acc   = (state_q == ST_DM_ACC) || (state_q == ST_IF_ACC);
  assign ack_dm   = (state_q == ST_DM_ACC) & mem.mem_ack;
  assign ack_if   = (state_q == ST_IF_ACC) & mem.mem_ack;
  assign grant    = pick_grant(dm_pend, if_req, last_grant_q);
  // An ack on the expiry cycle wins over the abort.
  assign finish   = in_acc & (mem.mem_ack | wd_expired);
  assign ret_data = mem.mem_ack ? mem.mem_rdata : ERR_DATA;

  access_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~in_acc | mem.mem_ack),
    .run     (in_acc),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_done_d     = 1'b0;
    dm_done_d     = 1'b0;
    err_timeout_d = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (dm_pend || if_req) begin
          mem_req_d = 1'b1;
          if (grant == GRANT_DM) begin
            state_d     = ST_DM_ACC;
            mem_we_d    = exm_mem_write;
            mem_addr_d  = exm_addr;
            mem_wdata_d = exm_wdata;
          end else begin
            state_d    = ST_IF_ACC;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end
      end
      ST_DM_ACC, ST_IF_ACC: begin
        if (finish) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem.mem_ack) begin
            last_grant_d = (state_q == ST_DM_ACC) ? GRANT_DM : GRANT_IF;
          end else begin
            err_timeout_d = 1'b1;
          end
          if (state_q == ST_DM_ACC) begin
            dm_done_d = 1'b1;
            // A completed store leaves the load data untouched; an aborted one reports ERR_DATA.
            if (!(mem.mem_ack && mem_we_q)) begin
              dm_rdata_d = ret_data;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = ret_data;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_IF;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_done_q     <= 1'b0;
      dm_done_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_done_q     <= if_done_d;
      dm_done_q     <= dm_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Stalls are combinational so EX/MEM advances on the very edge its access completes;
  // they are forced low while reset is held.
  assign stall_pipe  = reset & dm_pend & ~ack_dm;
  assign stall_fetch = reset & (stall_pipe | (if_req & ~ack_if));

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign dm_rdata      = dm_rdata_q;
  assign if_done       = if_done_q;
  assign dm_done       = dm_done_q;
  assign err_timeout   = err_timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store, timeout,
// async reset mid-access and alternating grants under continuous load.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          exm_mem_read;
  logic          exm_mem_write;
  logic [AW-1:0] exm_addr;
  logic [DW-1:0] exm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          stall_fetch;
  logic          stall_pipe;
  logic          err_timeout;
  arb_state_t    dbg_state;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) mif ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_done       (if_done),
    .exm_mem_read  (exm_mem_read),
    .exm_mem_write (exm_mem_write),
    .exm_addr      (exm_addr),
    .exm_wdata     (exm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_done       (dm_done),
    .stall_fetch   (stall_fetch),
    .stall_pipe    (stall_pipe),
    .err_timeout   (err_timeout),
    .dbg_state     (dbg_state),
    .mem           (mif.master)
  );

  int checks = 0;
  int errors = 0;

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset         = 1'b0;
    if_req        = 1'b0;
    if_addr       = '0;
    exm_mem_read  = 1'b0;
    exm_mem_write = 1'b0;
    exm_addr      = '0;
    exm_wdata     = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    tick();
    tick();

    // reset state
    check("rst_mem_req", 32'(mif.mem_req), 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_dm_done", 32'(dm_done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // single fetch, zero-wait memory
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    #1;
    check("f_stall_idle", 32'(stall_fetch), 32'd1);
    tick();
    check("f_state", 32'(dbg_state), 32'(ST_IF_ACC));
    check("f_mem_req", 32'(mif.mem_req), 32'd1);
    check("f_mem_we", 32'(mif.mem_we), 32'd0);
    check("f_mem_addr", mif.mem_addr, 32'h0040_0000);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h2008_0005;
    #1;
    check("f_stall_ack", 32'(stall_fetch), 32'd0);
    tick();
    check("f_if_done", 32'(if_done), 32'd1);
    check("f_if_rdata", if_rdata, 32'h2008_0005);
    check("f_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("f_req_drop", 32'(mif.mem_req), 32'd0);
    if_req      = 1'b0;
    mif.mem_ack = 1'b0;
    tick();
    check("f_done_pulse", 32'(if_done), 32'd0);

    // contention with last_grant=IF: data side first
    if_req       = 1'b1;
    if_addr      = 32'h0040_0004;
    exm_mem_read = 1'b1;
    exm_addr     = 32'h1001_0000;
    #1;
    check("c_stall_pipe0", 32'(stall_pipe), 32'd1);
    check("c_stall_fetch0", 32'(stall_fetch), 32'd1);
    tick();
    check("c_state_dm", 32'(dbg_state), 32'(ST_DM_ACC));
    check("c_addr_dm", mif.mem_addr, 32'h1001_0000);
    check("c_stall_pipe1", 32'(stall_pipe), 32'd1);
    tick();
    check("c_stall_pipe2", 32'(stall_pipe), 32'd1);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hCAFE_F00D;
    #1;
    check("c_stall_pipe_ack", 32'(stall_pipe), 32'd0);
    check("c_stall_fetch_ack", 32'(stall_fetch), 32'd1);
    tick();
    check("c_dm_done", 32'(dm_done), 32'd1);
    check("c_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    exm_mem_read = 1'b0;
    mif.mem_ack  = 1'b0;
    tick();
    check("c_state_if", 32'(dbg_state), 32'(ST_IF_ACC));
    check("c_addr_if", mif.mem_addr, 32'h0040_0004);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h8C08_0000;
    tick();
    check("c_if_done", 32'(if_done), 32'd1);
    check("c_if_rdata", if_rdata, 32'h8C08_0000);
    if_req      = 1'b0;
    mif.mem_ack = 1'b0;
    tick();

    // store with three wait states
    exm_mem_write = 1'b1;
    exm_addr      = 32'h1001_0004;
    exm_wdata     = 32'h1234_5678;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("s_mem_req", 32'(mif.mem_req), 32'd1);
      check("s_mem_we", 32'(mif.mem_we), 32'd1);
      check("s_mem_addr", mif.mem_addr, 32'h1001_0004);
      check("s_mem_wdata", mif.mem_wdata, 32'h1234_5678);
      check("s_no_done", 32'(dm_done), 32'd0);
      if (i == 3) mif.mem_ack = 1'b1;
      tick();
    end
    check("s_dm_done", 32'(dm_done), 32'd1);
    check("s_dm_rdata_kept", dm_rdata, 32'hCAFE_F00D);
    exm_mem_write = 1'b0;
    mif.mem_ack   = 1'b0;
    tick();
    check("s_single_done", 32'(dm_done), 32'd0);

    // load that never gets an ack
    exm_mem_read = 1'b1;
    exm_addr     = 32'h1001_0008;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("t_mem_req", 32'(mif.mem_req), 32'd1);
      check("t_err_low", 32'(err_timeout), 32'd0);
      tick();
    end
    check("t_req_drop", 32'(mif.mem_req), 32'd0);
    check("t_dm_done", 32'(dm_done), 32'd1);
    check("t_err_data", dm_rdata, 32'hDEAD_BEEF);
    check("t_err_set", 32'(err_timeout), 32'd1);
    check("t_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    exm_mem_read = 1'b0;
    tick();
    check("t_err_sticky", 32'(err_timeout), 32'd1);
    check("t_done_pulse", 32'(dm_done), 32'd0);

    // asynchronous reset in the middle of a data access
    exm_mem_read = 1'b1;
    exm_addr     = 32'h1001_0010;
    tick();
    check("r_req_before", 32'(mif.mem_req), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("r_mem_req", 32'(mif.mem_req), 32'd0);
    check("r_mem_addr", mif.mem_addr, 32'd0);
    check("r_err", 32'(err_timeout), 32'd0);
    check("r_stall_pipe", 32'(stall_pipe), 32'd0);
    check("r_dm_rdata", dm_rdata, 32'd0);
    check("r_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    reset = 1'b1;
    #1;
    check("r_idle_after", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    check("r_regrant", 32'(dbg_state), 32'(ST_DM_ACC));
    check("r_regrant_addr", mif.mem_addr, 32'h1001_0010);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h1111_2222;
    tick();
    check("r_dm_done", 32'(dm_done), 32'd1);
    check("r_dm_rdata2", dm_rdata, 32'h1111_2222);

    // continuous load + fetch with zero-wait memory: grants alternate, IF first
    if_req  = 1'b1;
    if_addr = 32'h0040_0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ((k % 2) == 0) begin
        check("a_state_if", 32'(dbg_state), 32'(ST_IF_ACC));
        check("a_addr_if", mif.mem_addr, 32'h0040_0100);
      end else begin
        check("a_state_dm", 32'(dbg_state), 32'(ST_DM_ACC));
        check("a_addr_dm", mif.mem_addr, 32'h1001_0010);
      end
      tick();
      if ((k % 2) == 0) check("a_if_done", 32'(if_done), 32'd1);
      else              check("a_dm_done", 32'(dm_done), 32'd1);
    end
    if_req       = 1'b0;
    exm_mem_read = 1'b0;
    mif.mem_ack  = 1'b0;
    tick();
    tick();
    check("a_final_idle", 32'(dbg_state), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
